// File: rtl/counter_t_pkg.sv
// ============================================================================
//  Module      : counter_t_pkg
//  Description : Shared direction constants and parameter legality check for
//                the T flip-flop based modulo counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_t_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // True when the stage count and modulus form a usable counter.
   function automatic bit params_legal(input int width, input int modulus);
      return (width >= 1) && (width <= 16) &&
             (modulus >= 2) && (modulus <= (1 << width));
   endfunction

endpackage

`default_nettype wire

// File: rtl/counter_t_sync_tff_cell.sv
// ============================================================================
//  Module      : tff_cell
//  Description : Single toggle flip-flop stage with synchronous parallel load;
//                the inverse output is a separately registered copy.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_cell (
   input  logic clk,
   input  logic rst,
   input  logic t,
   input  logic ld,
   input  logic ld_val,
   output logic q,
   output logic q_inverse
);

   logic r_q;
   logic r_q_inverse;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q         <= 1'b0;
         r_q_inverse <= 1'b1;
      end else if (ld) begin
         r_q         <= ld_val;
         r_q_inverse <= ~ld_val;
      end else if (t) begin
         r_q         <= ~r_q;
         r_q_inverse <= ~r_q_inverse;
      end
   end

   assign q         = r_q;
   assign q_inverse = r_q_inverse;

endmodule

`default_nettype wire

// File: rtl/counter_t_sync.sv
// ============================================================================
//  Module      : counter_t_sync
//  Description : Loadable modulo-N counter built from tff_cell stages, with a
//                combinational terminal-count output for cascading.
//                Define COUNTER_T_DOWN_EN to add the up port and down counting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_t_sync
   import counter_t_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
`ifdef COUNTER_T_DOWN_EN
   input  logic             up,
`endif
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_inverse,
   output logic             tc
);

   localparam logic [WIDTH-1:0] c_max_count = WIDTH'(MODULUS - 1);

   generate
      if (!params_legal(WIDTH, MODULUS)) begin : g_param_check
         $fatal(1, "counter_t_sync: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   logic             w_up;
   logic [WIDTH-1:0] w_t_up;
   logic [WIDTH-1:0] w_t;
   logic [WIDTH-1:0] w_ld_val;
   logic             w_up_wrap;

`ifdef COUNTER_T_DOWN_EN
   assign w_up = up;
`else
   assign w_up = DIR_UP;
`endif

   // Out-of-range counts are folded into the wrap so the next step recovers.
   assign w_up_wrap = (q >= c_max_count);
   assign w_ld_val  = (d > c_max_count) ? c_max_count : d;
   assign tc        = en & (q == ((w_up == DIR_UP) ? c_max_count : {WIDTH{1'b0}}));

   always_comb begin : p_t_up
      logic v_acc;
      v_acc  = 1'b1;
      w_t_up = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_t_up[i] = v_acc;
         v_acc     = v_acc & q[i];
      end
   end

`ifdef COUNTER_T_DOWN_EN
   logic [WIDTH-1:0] w_t_dn;
   logic             w_dn_wrap;

   assign w_dn_wrap = (q == '0) || (q > c_max_count);

   always_comb begin : p_t_dn
      logic v_acc;
      v_acc  = 1'b1;
      w_t_dn = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_t_dn[i] = v_acc;
         v_acc     = v_acc & q_inverse[i];
      end
   end
`endif

   // Wrap toggles are chosen so that q ^ t lands on the wrap target in one edge.
   always_comb begin : p_toggle
      w_t = '0;
      if (en) begin
         if (w_up == DIR_UP) begin
            w_t = w_up_wrap ? q : w_t_up;
         end
`ifdef COUNTER_T_DOWN_EN
         else begin
            w_t = w_dn_wrap ? (q ^ c_max_count) : w_t_dn;
         end
`endif
      end
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_stage
         tff_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .t         (w_t[i]),
            .ld        (load),
            .ld_val    (w_ld_val[i]),
            .q         (q[i]),
            .q_inverse (q_inverse[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire
